eth_tx_sched: RTL



---
 rtl/eth_tx_sched_pkg.sv | 27 ++
 rtl/eth_rr_arb.sv | 38 +++
 rtl/eth_tx_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eth_tx_sched_pkg : state encoding, 20 MHz timing defaults, width helper  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package eth_tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_WAIT_FALL = 3'd3,
    ST_IFG       = 3'd4,
    ST_NLP       = 3'd5
  } state_t;

  localparam int IFG_CYC_20M    = 192;
  localparam int NLP_PERIOD_20M = 320000;
  localparam int NLP_WIDTH_20M  = 2;

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eth_rr_arb : combinational round-robin pick, first request after ptr     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module eth_rr_arb
  import eth_tx_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan ptr+1 .. ptr+N_REQ cyclically so the last winner has lowest priority.
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % N_REQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eth_tx_sched : RR frame scheduler with IFG and NLP generation for 10BT.  |
// | ETH_TX_SCHED_STATS_EN adds frame_cnt/to_cnt counters.   Rev 1.0          |
// +--------------------------------------------------------------------------+
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int IFG_CYC    = IFG_CYC_20M,
  parameter int NLP_PERIOD = NLP_PERIOD_20M,
  parameter int NLP_WIDTH  = NLP_WIDTH_20M,
  parameter int START_TO   = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req,
  output logic [N_REQ-1:0]                gnt,
  output logic [clog2_min1(N_REQ)-1:0]    sel,
  output logic                            transmit,
  input  logic                            tx_w,
  output logic                            nlp,
  output logic                            busy,
  output logic                            err
`ifdef ETH_TX_SCHED_STATS_EN
  ,
  output logic [15:0]                     frame_cnt,
  output logic [7:0]                      to_cnt
`endif
);

  localparam int IDX_W    = clog2_min1(N_REQ);
  localparam int TMR_MAX0 = (IFG_CYC > START_TO) ? IFG_CYC : START_TO;
  localparam int TMR_MAX  = (TMR_MAX0 > NLP_WIDTH) ? TMR_MAX0 : NLP_WIDTH;
  localparam int TMR_W    = clog2_min1(TMR_MAX);
  localparam int NLP_W    = clog2_min1(NLP_PERIOD);

  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(START_TO - 1);
  localparam logic [TMR_W-1:0] IFG_LAST  = TMR_W'(IFG_CYC - 1);
  localparam logic [TMR_W-1:0] NLPW_LAST = TMR_W'(NLP_WIDTH - 1);
  localparam logic [NLP_W-1:0] NLP_LAST  = NLP_W'(NLP_PERIOD - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               transmit_q, transmit_d;
  logic               nlp_q, nlp_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [NLP_W-1:0]   nlp_cnt_q, nlp_cnt_d;

  logic               arb_valid;
  logic [N_REQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic               nlp_exp;

  eth_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (arb_valid),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  assign nlp_exp = (nlp_cnt_q == NLP_LAST);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    tmr_d      = tmr_q;
    gnt_d      = '0;
    transmit_d = 1'b0;
    err_d      = 1'b0;
    nlp_cnt_d  = nlp_exp ? nlp_cnt_q : nlp_cnt_q + NLP_W'(1);

    case (state_q)
      ST_IDLE: begin
        // A due link pulse always goes out before any frame.
        if (nlp_exp) begin
          state_d   = ST_NLP;
          tmr_d     = '0;
          nlp_cnt_d = '0;
        end else if (arb_valid) begin
          state_d    = ST_START;
          gnt_d      = arb_onehot;
          transmit_d = 1'b1;
          sel_d      = arb_idx;
          ptr_d      = arb_idx;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_RISE;
        tmr_d   = '0;
      end
      ST_WAIT_RISE: begin
        if (tx_w) begin
          state_d = ST_WAIT_FALL;
        end else if (tmr_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IFG;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_WAIT_FALL: begin
        if (!tx_w) begin
          state_d = ST_IFG;
          tmr_d   = '0;
        end
      end
      ST_IFG: begin
        if (tmr_q == IFG_LAST) begin
          state_d   = ST_IDLE;
          nlp_cnt_d = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_NLP: begin
        nlp_cnt_d = '0;
        if (tmr_q == NLPW_LAST) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    nlp_d  = (state_d == ST_NLP);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IDX_W'(N_REQ - 1);
      sel_q      <= '0;
      gnt_q      <= '0;
      transmit_q <= 1'b0;
      nlp_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      tmr_q      <= '0;
      nlp_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      transmit_q <= transmit_d;
      nlp_q      <= nlp_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      tmr_q      <= tmr_d;
      nlp_cnt_q  <= nlp_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign transmit = transmit_q;
  assign nlp      = nlp_q;
  assign busy     = busy_q;
  assign err      = err_q;

`ifdef ETH_TX_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;

  // Frame count wraps; timeout count sticks at its ceiling.
  always_comb begin
    frame_cnt_d = frame_cnt_q + (transmit_d ? 16'd1 : 16'd0);
    to_cnt_d    = (err_d && (to_cnt_q != 8'hFF)) ? to_cnt_q + 8'd1 : to_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign to_cnt    = to_cnt_q;
`endif

endmodule
`default_nettype wire
